// File: rtl/anchor_ebi_rd.sv
// EBI read-port engine: qualifies the synchronised read strobe, pops one FWFT word
// per accepted strobe, holds it on the EBI bus, counts frames and flags underflow.
module anchor_ebi_rd #(
    parameter int          DATA_W    = 16,
    parameter int          FRAME_LEN = 1024,
    parameter int          QUAL_CYC  = 2,
    parameter int unsigned FILL_WORD = 32'h0000_DEAD,
    localparam int         CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              rd_ena,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] ebi_dout,
    output logic              ebi_doe,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              frame_done,
    output logic              underflow,
    input  logic              underflow_clr,
    output logic [1:0]        dbg_state
);

    localparam int                QW       = (QUAL_CYC > 1) ? $clog2(QUAL_CYC) : 1;
    localparam logic [DATA_W-1:0] FILL_VAL = DATA_W'(FILL_WORD);
    localparam logic [QW-1:0]     Q_LAST   = QW'(QUAL_CYC - 1);
    localparam logic [CNT_W-1:0]  W_LAST   = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [QW-1:0]     r_qcnt;
    logic [QW-1:0]     w_next_qcnt;
    logic              w_accept;
    logic              w_last_word;

    logic [DATA_W-1:0] r_dout;
    logic              r_doe;
    logic              r_rd_en;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_frame_done;
    logic              r_underflow;

    assign w_last_word = (r_word_cnt == W_LAST);

    // The strobe is accepted on the QUAL_CYC-th consecutive high sample, once per strobe.
    always_comb begin
        w_next_state = r_state;
        w_next_qcnt  = r_qcnt;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_ena) begin
                    if (QUAL_CYC == 1) begin
                        w_accept     = 1'b1;
                        w_next_state = HOLD;
                    end else begin
                        w_next_state = QUAL;
                        w_next_qcnt  = QW'(1);
                    end
                end
            end
            QUAL: begin
                if (!rd_ena) begin
                    w_next_state = IDLE;
                    w_next_qcnt  = '0;
                end else if (r_qcnt == Q_LAST) begin
                    w_accept     = 1'b1;
                    w_next_state = HOLD;
                    w_next_qcnt  = '0;
                end else begin
                    w_next_qcnt  = r_qcnt + QW'(1);
                end
            end
            HOLD: begin
                if (!rd_ena) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_qcnt  = '0;
            end
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_state      <= IDLE;
            r_qcnt       <= '0;
            r_dout       <= '0;
            r_doe        <= 1'b0;
            r_rd_en      <= 1'b0;
            r_word_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_qcnt       <= w_next_qcnt;
            r_doe        <= (w_next_state == HOLD);
            r_rd_en      <= w_accept & ~fifo_empty;
            r_frame_done <= w_accept & w_last_word;
            if (w_accept) begin
                r_dout     <= fifo_empty ? FILL_VAL : fifo_dout;
                // Underflow reads still advance the frame so the host stays aligned.
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + CNT_W'(1);
            end
            if (w_accept && fifo_empty) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign fifo_rd_en = r_rd_en;
    assign ebi_dout   = r_dout;
    assign ebi_doe    = r_doe;
    assign word_cnt   = r_word_cnt;
    assign frame_done = r_frame_done;
    assign underflow  = r_underflow;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_anchor_ebi_rd.sv
// Directed bench for anchor_ebi_rd with QUAL_CYC=2 and a 4-word frame.
module tb_anchor_ebi_rd;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 4;
    localparam int QUAL_CYC  = 2;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    logic              rd_clk = 1'b0;
    logic              rd_rst_n;
    logic              rd_ena;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] ebi_dout;
    logic              ebi_doe;
    logic [CNT_W-1:0]  word_cnt;
    logic              frame_done;
    logic              underflow;
    logic              underflow_clr;
    logic [1:0]        dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    int pulses;

    always #5 rd_clk = ~rd_clk;

    anchor_ebi_rd #(
        .DATA_W   (DATA_W),
        .FRAME_LEN(FRAME_LEN),
        .QUAL_CYC (QUAL_CYC),
        .FILL_WORD(32'h0000_DEAD)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .rd_ena       (rd_ena),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .ebi_dout     (ebi_dout),
        .ebi_doe      (ebi_doe),
        .word_cnt     (word_cnt),
        .frame_done   (frame_done),
        .underflow    (underflow),
        .underflow_clr(underflow_clr),
        .dbg_state    (dbg_state)
    );

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge rd_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rd_rst_n      = 1'b0;
        rd_ena        = 1'b0;
        fifo_dout     = 16'h1234;
        fifo_empty    = 1'b0;
        underflow_clr = 1'b0;
        tick();
        tick();
        check("rst_doe", ebi_doe, 0);
        check("rst_dout", ebi_dout, 0);
        check("rst_wcnt", word_cnt, 0);
        check("rst_rden", fifo_rd_en, 0);
        check("rst_fdone", frame_done, 0);
        check("rst_uflow", underflow, 0);
        rd_rst_n = 1'b1;
        tick();

        // Two 4-cycle strobes, 2 low cycles between.
        rd_ena = 1'b1;
        tick();
        check("t1_qual_doe", ebi_doe, 0);
        check("t1_qual_rden", fifo_rd_en, 0);
        tick();
        check("t1_acc_doe", ebi_doe, 1);
        check("t1_acc_dout", ebi_dout, 16'h1234);
        check("t1_acc_rden", fifo_rd_en, 1);
        check("t1_acc_wcnt", word_cnt, 1);
        fifo_dout = 16'h5678;
        tick();
        check("t1_hold_doe", ebi_doe, 1);
        check("t1_hold_rden", fifo_rd_en, 0);
        tick();
        check("t1_hold2_doe", ebi_doe, 1);
        rd_ena = 1'b0;
        tick();
        check("t1_drop_doe", ebi_doe, 0);
        check("t1_drop_dout", ebi_dout, 16'h1234);
        tick();
        rd_ena = 1'b1;
        tick();
        check("t1b_qual_doe", ebi_doe, 0);
        tick();
        check("t1b_acc_dout", ebi_dout, 16'h5678);
        check("t1b_acc_rden", fifo_rd_en, 1);
        check("t1b_acc_wcnt", word_cnt, 2);
        fifo_dout = 16'hAAAA;
        tick();
        tick();
        rd_ena = 1'b0;
        tick();
        check("t1b_drop_doe", ebi_doe, 0);
        tick();

        // Single-cycle glitch.
        rd_ena = 1'b1;
        tick();
        rd_ena = 1'b0;
        tick();
        check("t2_doe", ebi_doe, 0);
        check("t2_rden", fifo_rd_en, 0);
        tick();
        check("t2_doe_late", ebi_doe, 0);
        check("t2_rden_late", fifo_rd_en, 0);
        check("t2_wcnt", word_cnt, 2);
        check("t2_dout", ebi_dout, 16'h5678);

        // Underflow, then clear racing a second underflow, then clear alone.
        fifo_empty = 1'b1;
        rd_ena = 1'b1;
        tick();
        tick();
        check("t3_dout", ebi_dout, 16'hDEAD);
        check("t3_rden", fifo_rd_en, 0);
        check("t3_uflow", underflow, 1);
        check("t3_wcnt", word_cnt, 3);
        check("t3_fdone", frame_done, 0);
        rd_ena = 1'b0;
        tick();
        rd_ena = 1'b1;
        tick();
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        check("t3_set_wins", underflow, 1);
        check("t3_wrap_wcnt", word_cnt, 0);
        check("t3_wrap_fdone", frame_done, 1);
        rd_ena = 1'b0;
        tick();
        check("t3_fdone_pulse", frame_done, 0);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        check("t3_clr", underflow, 0);
        fifo_empty = 1'b0;

        // Nine strobes across frame boundaries.
        for (int i = 1; i <= 9; i++) begin
            fifo_dout = DATA_W'(16'h0100 + i);
            rd_ena = 1'b1;
            tick();
            tick();
            check($sformatf("t4_wcnt_%0d", i), word_cnt, i % 4);
            check($sformatf("t4_fdone_%0d", i), frame_done, (i % 4) == 0);
            check($sformatf("t4_dout_%0d", i), ebi_dout, 16'h0100 + i);
            rd_ena = 1'b0;
            tick();
        end

        // Asynchronous reset while holding an underflow word.
        fifo_empty = 1'b1;
        rd_ena = 1'b1;
        tick();
        tick();
        check("t5_pre_doe", ebi_doe, 1);
        check("t5_pre_uflow", underflow, 1);
        check("t5_pre_wcnt", word_cnt, 2);
        #2;
        rd_rst_n = 1'b0;
        #1;
        check("t5_rst_doe", ebi_doe, 0);
        check("t5_rst_dout", ebi_dout, 0);
        check("t5_rst_wcnt", word_cnt, 0);
        check("t5_rst_uflow", underflow, 0);
        fifo_empty = 1'b0;
        fifo_dout  = 16'hBEEF;
        tick();
        rd_rst_n = 1'b1;
        tick();
        check("t5_requal_doe", ebi_doe, 0);
        pulses = 0;
        tick();
        check("t5_acc_doe", ebi_doe, 1);
        check("t5_acc_dout", ebi_dout, 16'hBEEF);
        check("t5_acc_wcnt", word_cnt, 1);
        for (int i = 0; i < 5; i++) begin
            if (fifo_rd_en) pulses++;
            tick();
        end
        check("t5_one_pulse", pulses, 1);
        rd_ena = 1'b0;
        tick();

        // Long strobe: one accept only.
        fifo_dout = 16'hC0DE;
        pulses = 0;
        rd_ena = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (fifo_rd_en) pulses++;
        end
        check("t6_doe_held", ebi_doe, 1);
        rd_ena = 1'b0;
        tick();
        if (fifo_rd_en) pulses++;
        check("t6_pulses", pulses, 1);
        check("t6_wcnt", word_cnt, 2);
        check("t6_dout", ebi_dout, 16'hC0DE);
        check("t6_doe_drop", ebi_doe, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
